counter_arbiter: RTL and testbench

COUNTER_ARBITER -- requirements
Module: counter_arbiter

---
 rtl/counter_arbiter.sv | 165 ++++++++++++++++
 tb/tb_counter_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/counter_arbiter.sv
// Two-requester round-robin arbiter that runs up/down step bursts on an
// external counter, aborting a burst when the observed count crosses a guard.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req0/req1         level burst requests, held until granted
//   dir0/dir1         requested direction (1 = up, 0 = down)
//   len0/len1         requested step count
//   cnt               observed counter value (signed)
//   gnt0/gnt1         one-cycle grant pulses
//   mode              direction driven to the counter
//   busy              high while a burst is in flight
//   done              one-cycle burst-complete pulse
//   abort             burst ended early by guard (valid with done)
//   steps             steps executed in the last burst (valid with done)
module counter_arbiter #(
    parameter int HI_GUARD = 229,
    parameter int LO_GUARD = -221
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              dir0,
    input  logic              dir1,
    input  logic [3:0]        len0,
    input  logic [3:0]        len1,
    input  logic signed [9:0] cnt,
    output logic              gnt0,
    output logic              gnt1,
    output logic              mode,
    output logic              busy,
    output logic              done,
    output logic              abort,
    output logic [3:0]        steps
);

    localparam int unsigned LEN_W = 4;
    localparam int unsigned CNT_W = 10;
    localparam logic signed [CNT_W-1:0] HI_LIM = CNT_W'(HI_GUARD);
    localparam logic signed [CNT_W-1:0] LO_LIM = CNT_W'(LO_GUARD);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_nx;
    logic               sel, sel_nx;
    logic               last, last_nx;
    logic               run_dir, run_dir_nx;
    logic [LEN_W-1:0]   run_len, run_len_nx;
    logic [LEN_W-1:0]   run_cnt, run_cnt_nx;
    logic               run_abort, run_abort_nx;
    logic               gnt0_nx, gnt1_nx, mode_nx, busy_nx, done_nx, abort_nx;
    logic [LEN_W-1:0]   steps_nx;

    logic               pick_c;
    logic               guard_c;
    logic [LEN_W-1:0]   req_len_c;
    logic               req_dir_c;

    // Round-robin pick: on contention serve the requester not served last.
    assign pick_c    = (req0 && req1) ? ~last : req1;
    assign req_len_c = pick_c ? len1 : len0;
    assign req_dir_c = pick_c ? dir1 : dir0;
    assign guard_c   = run_dir ? (cnt > HI_LIM) : (cnt < LO_LIM);

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sel       <= 1'b0;
            last      <= 1'b1;
            run_dir   <= 1'b1;
            run_len   <= '0;
            run_cnt   <= '0;
            run_abort <= 1'b0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            mode      <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            abort     <= 1'b0;
            steps     <= '0;
        end else begin
            state     <= state_nx;
            sel       <= sel_nx;
            last      <= last_nx;
            run_dir   <= run_dir_nx;
            run_len   <= run_len_nx;
            run_cnt   <= run_cnt_nx;
            run_abort <= run_abort_nx;
            gnt0      <= gnt0_nx;
            gnt1      <= gnt1_nx;
            mode      <= mode_nx;
            busy      <= busy_nx;
            done      <= done_nx;
            abort     <= abort_nx;
            steps     <= steps_nx;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nx     = state;
        sel_nx       = sel;
        last_nx      = last;
        run_dir_nx   = run_dir;
        run_len_nx   = run_len;
        run_cnt_nx   = run_cnt;
        run_abort_nx = run_abort;
        gnt0_nx      = 1'b0;
        gnt1_nx      = 1'b0;
        mode_nx      = mode;
        done_nx      = 1'b0;
        abort_nx     = abort;
        steps_nx     = steps;

        unique case (state)
            IDLE: begin
                if (req0 || req1) begin
                    sel_nx       = pick_c;
                    run_dir_nx   = req_dir_c;
                    run_len_nx   = req_len_c;
                    run_cnt_nx   = '0;
                    run_abort_nx = 1'b0;
                    gnt0_nx      = ~pick_c;
                    gnt1_nx      = pick_c;
                    if (req_len_c == '0) begin
                        // Empty burst: skip RUN, mode left untouched
                        state_nx = DONE;
                    end else begin
                        state_nx = RUN;
                        mode_nx  = req_dir_c;
                    end
                end
            end
            RUN: begin
                // Guard wins over length completion and the cycle is not counted
                if (guard_c) begin
                    run_abort_nx = 1'b1;
                    state_nx     = DONE;
                end else begin
                    run_cnt_nx = run_cnt + LEN_W'(1);
                    if (run_cnt + LEN_W'(1) == run_len) begin
                        state_nx = DONE;
                    end
                end
            end
            DONE: begin
                // Publish burst result and record who was served
                done_nx  = 1'b1;
                steps_nx = run_cnt;
                abort_nx = run_abort;
                last_nx  = sel;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase

        busy_nx = (state_nx != IDLE);
    end

endmodule

// File: tb/tb_counter_arbiter.sv
// Self-checking bench for counter_arbiter: burst-level reference model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_counter_arbiter;

    localparam int HI = 229;
    localparam int LO = -221;

    logic              clk = 1'b0;
    logic              rst;
    logic              req0, req1, dir0, dir1;
    logic [3:0]        len0, len1;
    logic signed [9:0] cnt;
    logic              gnt0, gnt1, mode, busy, done, abort;
    logic [3:0]        steps;

    int n_cmp = 0;
    int n_bad = 0;

    counter_arbiter #(.HI_GUARD(HI), .LO_GUARD(LO)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .dir0(dir0), .dir1(dir1),
        .len0(len0), .len1(len1), .cnt(cnt),
        .gnt0(gnt0), .gnt1(gnt1), .mode(mode), .busy(busy),
        .done(done), .abort(abort), .steps(steps)
    );

    always #5 clk = ~clk;

    // Burst-level model: a burst is a grant edge, an end edge (length reached,
    // guard hit, or immediately for empty bursts) and a publish edge after it.
    logic       e_gnt0, e_gnt1, e_mode, e_busy, e_done, e_abort;
    logic [3:0] e_steps;
    bit         model_ok = 0;
    bit         active, m_last, m_who, m_dir, m_ab;
    int         t = 0, g_edge, end_edge, m_len, m_steps, k;

    always @(posedge clk) begin
        t++;
        if (rst) begin
            active = 0; m_last = 1;
            e_gnt0 = 0; e_gnt1 = 0; e_busy = 0; e_done = 0; e_abort = 0;
            e_mode = 1; e_steps = 0;
            model_ok = 1;
        end else if (model_ok) begin
            e_gnt0 = 0; e_gnt1 = 0; e_done = 0;
            if (active && end_edge >= 0) begin
                if (t == end_edge + 1) begin
                    e_done  = 1;
                    e_steps = 4'(m_steps);
                    e_abort = m_ab;
                    m_last  = m_who;
                    active  = 0;
                end
            end else if (active) begin
                k = t - g_edge;
                if ((m_dir && int'(cnt) > HI) || (!m_dir && int'(cnt) < LO)) begin
                    end_edge = t; m_steps = k - 1; m_ab = 1;
                end else if (k == m_len) begin
                    end_edge = t; m_steps = m_len; m_ab = 0;
                end
            end else if (req0 || req1) begin
                m_who  = (req0 && req1) ? !m_last : req1;
                m_dir  = m_who ? dir1 : dir0;
                m_len  = int'(m_who ? len1 : len0);
                g_edge = t;
                active = 1;
                m_ab   = 0;
                if (m_who) e_gnt1 = 1; else e_gnt0 = 1;
                if (m_len == 0) begin
                    end_edge = t; m_steps = 0;
                end else begin
                    end_edge = -1; e_mode = m_dir;
                end
            end
            e_busy = active;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (model_ok) begin
            n_cmp += 8;
            if (gnt0 !== e_gnt0) begin n_bad++; $display("FAIL model_gnt0 t=%0d got=%b exp=%b", t, gnt0, e_gnt0); end
            if (gnt1 !== e_gnt1) begin n_bad++; $display("FAIL model_gnt1 t=%0d got=%b exp=%b", t, gnt1, e_gnt1); end
            if (mode !== e_mode) begin n_bad++; $display("FAIL model_mode t=%0d got=%b exp=%b", t, mode, e_mode); end
            if (busy !== e_busy) begin n_bad++; $display("FAIL model_busy t=%0d got=%b exp=%b", t, busy, e_busy); end
            if (done !== e_done) begin n_bad++; $display("FAIL model_done t=%0d got=%b exp=%b", t, done, e_done); end
            if (abort !== e_abort) begin n_bad++; $display("FAIL model_abort t=%0d got=%b exp=%b", t, abort, e_abort); end
            if (steps !== e_steps) begin n_bad++; $display("FAIL model_steps t=%0d got=%0d exp=%0d", t, steps, e_steps); end
            if ((gnt0 & gnt1) !== 1'b0) begin n_bad++; $display("FAIL onehot_gnt t=%0d got=%b%b exp=not both", t, gnt0, gnt1); end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic wait_idle(input int max_cycles);
        bit ok = 0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin ok = 1; break; end
        end
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL wait_idle got=busy exp=idle within %0d", max_cycles); end
        @(negedge clk);
    endtask

    int gwho[$];
    int gcyc[$];

    initial begin
        rst = 1; req0 = 0; req1 = 0; dir0 = 0; dir1 = 0;
        len0 = 0; len1 = 0; cnt = 0;
        repeat (2) @(negedge clk);

        // Reset values
        chk("rst_busy", busy, 0);
        chk("rst_mode", mode, 1);
        chk("rst_steps", steps, 0);
        chk("rst_gnt0", gnt0, 0);
        chk("rst_done", done, 0);

        // Basic up burst of 3
        rst = 0; req0 = 1; dir0 = 1; len0 = 3; cnt = -50;
        @(negedge clk);
        chk("b3_gnt0", gnt0, 1); chk("b3_busy", busy, 1); chk("b3_mode1", mode, 1);
        req0 = 0;
        @(negedge clk); chk("b3_gnt0_pulse", gnt0, 0); chk("b3_mode2", mode, 1);
        @(negedge clk); chk("b3_mode3", mode, 1);
        @(negedge clk); chk("b3_busy_done_state", busy, 1); chk("b3_no_early_done", done, 0);
        @(negedge clk);
        chk("b3_done", done, 1); chk("b3_steps", steps, 3);
        chk("b3_abort", abort, 0); chk("b3_busy_after", busy, 0);
        @(negedge clk); chk("b3_done_pulse", done, 0);

        // Round-robin with both requesters held
        rst = 1;
        @(negedge clk);
        rst = 0; req0 = 1; req1 = 1; dir0 = 1; dir1 = 1; len0 = 2; len1 = 2; cnt = 0;
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk);
            if (gnt0) begin gwho.push_back(0); gcyc.push_back(i); end
            if (gnt1) begin gwho.push_back(1); gcyc.push_back(i); end
        end
        req0 = 0; req1 = 0;
        chk("rr_count", gwho.size(), 6);
        for (int i = 0; i < gwho.size(); i++) begin
            chk("rr_order", gwho[i], i % 2);
            if (i > 0) chk("rr_spacing", gcyc[i] - gcyc[i-1], 4);
        end
        wait_idle(20);

        // Up-guard abort on 2nd RUN cycle
        req1 = 1; dir1 = 1; len1 = 15; cnt = 0;
        @(negedge clk); chk("ab_gnt1", gnt1, 1); chk("ab_gnt0", gnt0, 0);
        req1 = 0;
        @(negedge clk); cnt = 230;
        @(negedge clk); chk("ab_busy", busy, 1); chk("ab_no_done", done, 0);
        @(negedge clk);
        chk("ab_done", done, 1); chk("ab_abort", abort, 1); chk("ab_steps", steps, 1);
        cnt = 0;
        @(negedge clk);

        // Zero-length burst
        req0 = 1; dir0 = 0; len0 = 0;
        @(negedge clk); chk("z_gnt0", gnt0, 1); chk("z_busy", busy, 1); chk("z_done_early", done, 0);
        req0 = 0;
        @(negedge clk);
        chk("z_done", done, 1); chk("z_steps", steps, 0); chk("z_abort", abort, 0);
        chk("z_mode_kept", mode, 1);
        @(negedge clk);

        // Reset in the middle of a long down burst
        req0 = 1; dir0 = 0; len0 = 8; cnt = 0;
        @(negedge clk); chk("mr_gnt0", gnt0, 1); chk("mr_mode", mode, 0);
        req0 = 0;
        @(negedge clk);
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0;
        chk("mr_busy", busy, 0); chk("mr_mode_rst", mode, 1); chk("mr_steps", steps, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); chk("mr_no_done", done, 0);
        end
        req0 = 1; req1 = 1; len0 = 1; len1 = 1; dir0 = 1; dir1 = 1;
        @(negedge clk); chk("mr_prio_gnt0", gnt0, 1); chk("mr_prio_gnt1", gnt1, 0);
        req0 = 0; req1 = 0;
        wait_idle(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
